// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto a single downstream memory port.
// Latency: grant in the request cycle, downstream request on the next cycle, read data passed through combinationally.
// Backpressure: one transaction in flight; req_ready stays low until the FSM is back in IDLE, response ready passes straight through.
module mem_arbiter #(
  parameter int DATA_PRIO = 1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction side
  input  logic [31:0] inst_addr,
  input  logic        inst_req_valid,
  output logic        inst_req_ready,
  output logic [31:0] inst_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  // data side
  input  logic [31:0] data_addr,
  input  logic        data_wen,
  input  logic        data_ren,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_req_ready,
  output logic [31:0] data_rdata,
  output logic        data_rvalid,
  input  logic        data_rready,
  // downstream memory
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_req_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  // statistics
  output logic [31:0] conflict_cnt
);

  localparam logic PRIO_DATA = (DATA_PRIO != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 1 = data side owns the transaction
  logic        last_q, last_d;     // 1 = data side won the most recent grant
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] cnt_q, cnt_d;

  logic inst_v, data_v, conflict, grant_data, rsp_rdy;

  // Request decode and winner selection; a lone requester always wins.
  always_comb begin
    inst_v     = inst_req_valid;
    data_v     = data_wen | data_ren;
    conflict   = inst_v & data_v;
    grant_data = data_v & (~inst_v | PRIO_DATA | ~last_q);
  end

  // Next-state logic and all outputs; outputs default low so reset and idle states are quiet.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    wr_d           = wr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    cnt_d          = cnt_q;
    rsp_rdy        = 1'b0;
    inst_req_ready = 1'b0;
    data_req_ready = 1'b0;
    inst_rdata     = 32'h0;
    inst_valid     = 1'b0;
    data_rdata     = 32'h0;
    data_rvalid    = 1'b0;
    mem_addr       = 32'h0;
    mem_wen        = 1'b0;
    mem_ren        = 1'b0;
    mem_wdata      = 32'h0;
    mem_wstrb      = 4'h0;
    mem_rready     = 1'b0;

    case (state_q)
      IDLE: begin
        // rst gates the grant so req_ready reads 0 while reset is held
        if (rst && (inst_v || data_v)) begin
          state_d = ISSUE;
          owner_d = grant_data;
          last_d  = grant_data;
          if (grant_data) begin
            data_req_ready = 1'b1;
            addr_d         = data_addr;
            wr_d           = data_wen;  // wen wins when both wen and ren are set
            wdata_d        = data_wen ? data_wdata : 32'h0;
            wstrb_d        = data_wen ? data_wstrb : 4'h0;
          end else begin
            inst_req_ready = 1'b1;
            addr_d         = inst_addr;
            wr_d           = 1'b0;
            wdata_d        = 32'h0;
            wstrb_d        = 4'h0;
          end
          if (conflict && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end

      ISSUE: begin
        mem_addr  = addr_q;
        mem_wen   = wr_q;
        mem_ren   = ~wr_q;
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
        if (mem_req_ready) begin
          state_d = wr_q ? IDLE : WAIT_R;
        end
      end

      WAIT_R: begin
        rsp_rdy = owner_q ? data_rready : inst_ready;
        mem_rready = rsp_rdy;
        if (owner_q) begin
          data_rdata  = mem_rdata;
          data_rvalid = mem_rvalid;
        end else begin
          inst_rdata  = mem_rdata;
          inst_valid  = mem_rvalid;
        end
        if (mem_rvalid && rsp_rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched transaction registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // pretend data won last so inst goes first
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is round-robin, instance 1 gives data priority.
// Stimulus pushes expected downstream requests and responses; a negedge monitor pops and compares.
// Directed checks cover reset, stalls, re-grant timing and the conflict counter.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  logic [31:0] inst_addr      [2];
  logic        inst_req_valid [2];
  logic        inst_req_ready [2];
  logic [31:0] inst_rdata     [2];
  logic        inst_valid     [2];
  logic        inst_ready     [2];
  logic [31:0] data_addr      [2];
  logic        data_wen       [2];
  logic        data_ren       [2];
  logic [31:0] data_wdata     [2];
  logic [3:0]  data_wstrb     [2];
  logic        data_req_ready [2];
  logic [31:0] data_rdata     [2];
  logic        data_rvalid    [2];
  logic        data_rready    [2];
  logic [31:0] mem_addr       [2];
  logic        mem_wen        [2];
  logic        mem_ren        [2];
  logic [31:0] mem_wdata      [2];
  logic [3:0]  mem_wstrb      [2];
  logic        mem_req_ready  [2];
  logic [31:0] mem_rdata      [2];
  logic        mem_rvalid     [2];
  logic        mem_rready     [2];
  logic [31:0] conflict_cnt   [2];

  mem_arbiter #(.DATA_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr[0]), .inst_req_valid(inst_req_valid[0]), .inst_req_ready(inst_req_ready[0]),
    .inst_rdata(inst_rdata[0]), .inst_valid(inst_valid[0]), .inst_ready(inst_ready[0]),
    .data_addr(data_addr[0]), .data_wen(data_wen[0]), .data_ren(data_ren[0]),
    .data_wdata(data_wdata[0]), .data_wstrb(data_wstrb[0]), .data_req_ready(data_req_ready[0]),
    .data_rdata(data_rdata[0]), .data_rvalid(data_rvalid[0]), .data_rready(data_rready[0]),
    .mem_addr(mem_addr[0]), .mem_wen(mem_wen[0]), .mem_ren(mem_ren[0]),
    .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .mem_req_ready(mem_req_ready[0]),
    .mem_rdata(mem_rdata[0]), .mem_rvalid(mem_rvalid[0]), .mem_rready(mem_rready[0]),
    .conflict_cnt(conflict_cnt[0])
  );

  mem_arbiter #(.DATA_PRIO(1)) u_dp (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr[1]), .inst_req_valid(inst_req_valid[1]), .inst_req_ready(inst_req_ready[1]),
    .inst_rdata(inst_rdata[1]), .inst_valid(inst_valid[1]), .inst_ready(inst_ready[1]),
    .data_addr(data_addr[1]), .data_wen(data_wen[1]), .data_ren(data_ren[1]),
    .data_wdata(data_wdata[1]), .data_wstrb(data_wstrb[1]), .data_req_ready(data_req_ready[1]),
    .data_rdata(data_rdata[1]), .data_rvalid(data_rvalid[1]), .data_rready(data_rready[1]),
    .mem_addr(mem_addr[1]), .mem_wen(mem_wen[1]), .mem_ren(mem_ren[1]),
    .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .mem_req_ready(mem_req_ready[1]),
    .mem_rdata(mem_rdata[1]), .mem_rvalid(mem_rvalid[1]), .mem_rready(mem_rready[1]),
    .conflict_cnt(conflict_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic        side;   // 1 = data side
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    int          dut;
    logic        side;
    logic [31:0] data;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  req_t mr;
  rsp_t ms;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input int d, input logic side, input logic [31:0] a,
                          input logic w, input logic [31:0] wd, input logic [3:0] ws);
    req_t r;
    r.dut = d; r.side = side; r.addr = a; r.wen = w; r.wdata = wd; r.wstrb = ws;
    exp_req.push_back(r);
  endtask

  task automatic push_rsp(input int d, input logic side, input logic [31:0] data);
    rsp_t r;
    r.dut = d; r.side = side; r.data = data;
    exp_rsp.push_back(r);
  endtask

  task automatic check_rsp(input int d, input logic side, input logic [31:0] data);
    if (exp_rsp.size() == 0) begin
      chk("rsp_expected", 32'(exp_rsp.size()), 32'd1);
    end else begin
      ms = exp_rsp.pop_front();
      chk("rsp_dut", 32'(d), 32'(ms.dut));
      chk("rsp_side", {31'd0, side}, {31'd0, ms.side});
      chk("rsp_data", data, ms.data);
    end
  endtask

  // Monitor: every accepted downstream request and every completed response is scored.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if ((mem_wen[d] || mem_ren[d]) && mem_req_ready[d]) begin
        if (exp_req.size() == 0) begin
          chk("mem_req_expected", 32'(exp_req.size()), 32'd1);
        end else begin
          mr = exp_req.pop_front();
          chk("mem_req_dut", 32'(d), 32'(mr.dut));
          chk("mem_req_addr", mem_addr[d], mr.addr);
          chk("mem_req_wen", {31'd0, mem_wen[d]}, {31'd0, mr.wen});
          chk("mem_req_ren", {31'd0, mem_ren[d]}, {31'd0, ~mr.wen});
          if (mr.wen) begin
            chk("mem_req_wdata", mem_wdata[d], mr.wdata);
            chk("mem_req_wstrb", {28'd0, mem_wstrb[d]}, {28'd0, mr.wstrb});
          end
          if (!mr.side) chk("mem_req_inst_wstrb", {28'd0, mem_wstrb[d]}, 32'd0);
        end
      end
      if (inst_valid[d] && inst_ready[d]) check_rsp(d, 1'b0, inst_rdata[d]);
      if (data_rvalid[d] && data_rready[d]) check_rsp(d, 1'b1, data_rdata[d]);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input int d);
    inst_addr[d] = 32'h0; inst_req_valid[d] = 1'b0; inst_ready[d] = 1'b0;
    data_addr[d] = 32'h0; data_wen[d] = 1'b0; data_ren[d] = 1'b0;
    data_wdata[d] = 32'h0; data_wstrb[d] = 4'h0; data_rready[d] = 1'b0;
    mem_req_ready[d] = 1'b0; mem_rdata[d] = 32'h0; mem_rvalid[d] = 1'b0;
  endtask

  int   ni, nd, exp_conf;
  logic last_data, win_data, both;
  logic [31:0] win_addr;

  // Watchdog: all tests run a fixed number of cycles, this only guards against a hung simulator.
  initial begin
    #50000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b0;
    clr(0); clr(1);
    inst_req_valid[1] = 1'b1; inst_addr[1] = 32'h100;
    inst_ready[1] = 1'b1; mem_rvalid[1] = 1'b1;
    #2;
    chk("rst_inst_req_ready", {31'd0, inst_req_ready[1]}, 32'd0);
    chk("rst_mem_ren", {31'd0, mem_ren[1]}, 32'd0);
    chk("rst_mem_rready", {31'd0, mem_rready[1]}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid[1]}, 32'd0);
    chk("rst_conflict_cnt", conflict_cnt[1], 32'd0);
    repeat (2) @(posedge clk);
    #1;
    clr(1);
    rst = 1'b1;
    tick();

    // ---------------- lone inst read ----------------
    inst_addr[1] = 32'h100; inst_req_valid[1] = 1'b1;
    mem_req_ready[1] = 1'b1; inst_ready[1] = 1'b1; data_rready[1] = 1'b1;
    push_req(1, 1'b0, 32'h100, 1'b0, 32'h0, 4'h0);
    #1;
    chk("a_inst_req_ready_c0", {31'd0, inst_req_ready[1]}, 32'd1);
    chk("a_mem_ren_c0", {31'd0, mem_ren[1]}, 32'd0);
    tick();
    inst_req_valid[1] = 1'b0;
    #1;
    chk("a_mem_ren_c1", {31'd0, mem_ren[1]}, 32'd1);
    chk("a_inst_req_ready_c1", {31'd0, inst_req_ready[1]}, 32'd0);
    tick();
    #1;
    chk("a_inst_valid_early", {31'd0, inst_valid[1]}, 32'd0);
    tick();
    mem_rvalid[1] = 1'b1; mem_rdata[1] = 32'hDEAD_BEEF;
    push_rsp(1, 1'b0, 32'hDEAD_BEEF);
    #1;
    chk("a_data_rvalid", {31'd0, data_rvalid[1]}, 32'd0);
    chk("a_mem_rready", {31'd0, mem_rready[1]}, 32'd1);
    tick();
    mem_rvalid[1] = 1'b0; mem_rdata[1] = 32'h0;

    // ---------------- data priority conflict ----------------
    inst_addr[1] = 32'h200; inst_req_valid[1] = 1'b1;
    data_addr[1] = 32'h300; data_ren[1] = 1'b1;
    push_req(1, 1'b1, 32'h300, 1'b0, 32'h0, 4'h0);
    push_req(1, 1'b0, 32'h200, 1'b0, 32'h0, 4'h0);
    #1;
    chk("b_data_req_ready", {31'd0, data_req_ready[1]}, 32'd1);
    chk("b_inst_req_ready", {31'd0, inst_req_ready[1]}, 32'd0);
    tick();
    data_ren[1] = 1'b0;
    #1;
    chk("b_inst_held_in_issue", {31'd0, inst_req_ready[1]}, 32'd0);
    chk("b_cnt_after_conflict", conflict_cnt[1], 32'd1);
    tick();
    mem_rvalid[1] = 1'b1; mem_rdata[1] = 32'hA000_0300;
    push_rsp(1, 1'b1, 32'hA000_0300);
    #1;
    chk("b_nonowner_inst_valid", {31'd0, inst_valid[1]}, 32'd0);
    chk("b_inst_held_in_wait", {31'd0, inst_req_ready[1]}, 32'd0);
    tick();
    mem_rvalid[1] = 1'b0;
    #1;
    chk("b_regrant_on_idle", {31'd0, inst_req_ready[1]}, 32'd1);
    tick();
    inst_req_valid[1] = 1'b0;
    tick();
    mem_rvalid[1] = 1'b1; mem_rdata[1] = 32'hB000_0200;
    push_rsp(1, 1'b0, 32'hB000_0200);
    #1;
    chk("b_nonowner_data_rvalid", {31'd0, data_rvalid[1]}, 32'd0);
    tick();
    mem_rvalid[1] = 1'b0;
    #1;
    chk("b_cnt_final", conflict_cnt[1], 32'd1);

    // ---------------- stalled write (wen+ren => write) ----------------
    data_addr[1] = 32'h40; data_wdata[1] = 32'h1234_5678; data_wstrb[1] = 4'h3;
    data_wen[1] = 1'b1; data_ren[1] = 1'b1; mem_req_ready[1] = 1'b0;
    push_req(1, 1'b1, 32'h40, 1'b1, 32'h1234_5678, 4'h3);
    #1;
    chk("c_data_req_ready", {31'd0, data_req_ready[1]}, 32'd1);
    tick();
    data_wen[1] = 1'b0; data_ren[1] = 1'b0;
    data_wdata[1] = 32'hFFFF_FFFF; data_wstrb[1] = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("c_hold_wen", {31'd0, mem_wen[1]}, 32'd1);
      chk("c_hold_ren", {31'd0, mem_ren[1]}, 32'd0);
      chk("c_hold_addr", mem_addr[1], 32'h40);
      chk("c_hold_wdata", mem_wdata[1], 32'h1234_5678);
      chk("c_hold_wstrb", {28'd0, mem_wstrb[1]}, 32'h3);
      tick();
    end
    mem_req_ready[1] = 1'b1;
    tick();

    // ---------------- response backpressure ----------------
    inst_addr[1] = 32'h500; inst_req_valid[1] = 1'b1; inst_ready[1] = 1'b0;
    push_req(1, 1'b0, 32'h500, 1'b0, 32'h0, 4'h0);
    #1;
    chk("d_grant_after_write", {31'd0, inst_req_ready[1]}, 32'd1);
    chk("d_mem_wen_idle", {31'd0, mem_wen[1]}, 32'd0);
    tick();
    inst_req_valid[1] = 1'b0;
    tick();
    mem_rvalid[1] = 1'b1; mem_rdata[1] = 32'hCAFE_F00D;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("d_mem_rready_stall", {31'd0, mem_rready[1]}, 32'd0);
      chk("d_inst_valid_stall", {31'd0, inst_valid[1]}, 32'd1);
      tick();
    end
    inst_ready[1] = 1'b1;
    push_rsp(1, 1'b0, 32'hCAFE_F00D);
    #1;
    chk("d_mem_rready_go", {31'd0, mem_rready[1]}, 32'd1);
    tick();
    mem_rvalid[1] = 1'b0;

    // ---------------- reset while waiting for read data ----------------
    inst_addr[1] = 32'h600; inst_req_valid[1] = 1'b1;
    push_req(1, 1'b0, 32'h600, 1'b0, 32'h0, 4'h0);
    tick();
    inst_req_valid[1] = 1'b0;
    tick();
    rst = 1'b0;
    mem_rvalid[1] = 1'b1; mem_rdata[1] = 32'h6666_6666;
    #1;
    chk("e_rst_inst_valid", {31'd0, inst_valid[1]}, 32'd0);
    chk("e_rst_mem_rready", {31'd0, mem_rready[1]}, 32'd0);
    chk("e_rst_conflict_cnt", conflict_cnt[1], 32'd0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("e_post_inst_valid", {31'd0, inst_valid[1]}, 32'd0);
      chk("e_post_data_rvalid", {31'd0, data_rvalid[1]}, 32'd0);
      chk("e_post_mem_rready", {31'd0, mem_rready[1]}, 32'd0);
      chk("e_post_mem_ren", {31'd0, mem_ren[1]}, 32'd0);
      tick();
    end
    clr(1);

    // ---------------- round-robin with both sides always requesting ----------------
    ni = 0; nd = 0; exp_conf = 0; last_data = 1'b1;
    inst_ready[0] = 1'b1; data_rready[0] = 1'b1; mem_req_ready[0] = 1'b1;
    while (ni < 4 || nd < 4) begin
      mem_rvalid[0] = 1'b0;
      inst_req_valid[0] = (ni < 4); inst_addr[0] = 32'h1000 + 32'(ni) * 32'h10;
      data_ren[0] = (nd < 4);       data_addr[0] = 32'h2000 + 32'(nd) * 32'h10;
      both     = (ni < 4) && (nd < 4);
      win_data = (nd < 4) && (!(ni < 4) || !last_data);
      win_addr = win_data ? data_addr[0] : inst_addr[0];
      push_req(0, win_data, win_addr, 1'b0, 32'h0, 4'h0);
      #1;
      chk("f_inst_req_ready", {31'd0, inst_req_ready[0]}, {31'd0, ~win_data});
      chk("f_data_req_ready", {31'd0, data_req_ready[0]}, {31'd0, win_data});
      tick();
      if (win_data) nd++; else ni++;
      last_data = win_data;
      if (both) exp_conf++;
      inst_req_valid[0] = (ni < 4); inst_addr[0] = 32'h1000 + 32'(ni) * 32'h10;
      data_ren[0] = (nd < 4);       data_addr[0] = 32'h2000 + 32'(nd) * 32'h10;
      #1;
      chk("f_conflict_cnt", conflict_cnt[0], 32'(exp_conf));
      chk("f_no_grant_in_issue", {31'd0, inst_req_ready[0] | data_req_ready[0]}, 32'd0);
      tick();
      mem_rvalid[0] = 1'b1; mem_rdata[0] = win_addr ^ 32'h5A5A_0000;
      push_rsp(0, win_data, win_addr ^ 32'h5A5A_0000);
      tick();
    end
    mem_rvalid[0] = 1'b0;
    clr(0);
    tick();
    chk("f_conflict_total", conflict_cnt[0], 32'd7);

    // ---------------- drain ----------------
    repeat (2) tick();
    chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_PRIO, default 1; 1 = data side always wins a conflict, 0 = round-robin between the inst and data sides.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: inst_addr  in  32  instruction fetch address.
REQ-005 Port: inst_req_valid / inst_req_ready  in / out  1 each  instruction request handshake.
REQ-006 Port: inst_rdata  out  32  instruction response data.
REQ-007 Port: inst_valid / inst_ready  out / in  1 each  instruction response handshake.
REQ-008 Port: data_addr  in  32  data request address.
REQ-009 Port: data_wen, data_ren  in  1 each  data write / read request (request valid = wen | ren).
REQ-010 Port: data_wdata  in  32  write data.
REQ-011 Port: data_wstrb  in  4  write byte strobes.
REQ-012 Port: data_req_ready  out  1  data request accepted.
REQ-013 Port: data_rdata  out  32  read response data.
REQ-014 Port: data_rvalid / data_rready  out / in  1 each  read response handshake.
REQ-015 Port: mem_addr  out  32  downstream address.
REQ-016 Port: mem_wen, mem_ren  out  1 each  downstream write / read request.
REQ-017 Port: mem_wdata  out  32  downstream write data.
REQ-018 Port: mem_wstrb  out  4  downstream write strobes.
REQ-019 Port: mem_req_ready  in  1  downstream request accepted.
REQ-020 Port: mem_rdata  in  32  downstream read data.
REQ-021 Port: mem_rvalid / mem_rready  in / out  1 each  downstream read response handshake.
REQ-022 Port: conflict_cnt  out  32  count of cycles where both sides requested in IDLE.

Function
REQ-023 The FSM SHALL have three states: IDLE, ISSUE and WAIT_R; at most one transaction is outstanding.
REQ-024 In IDLE, when any request is valid, the arbiter SHALL pick a winner, pulse that side's req_ready for one cycle, latch owner, address, type, wdata and wstrb, and go to ISSUE.
REQ-025 An instruction request SHALL always be a read; wstrb SHALL be 0.
REQ-026 If data_wen and data_ren are both high, the request SHALL be treated as a write.
REQ-027 With DATA_PRIO=1, a conflict SHALL grant the data side.
REQ-028 With DATA_PRIO=0, a conflict SHALL grant the side not granted last; after reset, inst goes first.
REQ-029 A non-conflicting request SHALL be granted immediately regardless of DATA_PRIO.
REQ-030 In ISSUE, mem_* SHALL be driven only from latched values, with mem_wen or mem_ren held high until mem_req_ready.
  - Write accepted -> IDLE.
  - Read accepted -> WAIT_R.
REQ-031 In WAIT_R, the owner's response pins SHALL be driven combinationally from the downstream:
  - owner rdata = mem_rdata; owner valid = mem_rvalid; mem_rready = owner ready.
  - Non-owner valid SHALL be 0.
REQ-032 In WAIT_R, when mem_rvalid & mem_rready, the FSM SHALL return to IDLE.
REQ-033 Both req_ready outputs SHALL be 0 outside IDLE; new requests wait.
REQ-034 Latency: request-to-downstream-request is 1 cycle, and a grant SHALL be possible in the cycle the FSM returns to IDLE.
REQ-035 conflict_cnt SHALL increment when both sides request in IDLE, and SHALL saturate at 0xFFFFFFFF.
REQ-036 mem_rvalid outside WAIT_R SHALL be ignored, with mem_rready = 0.

Reset
REQ-037 While rst=0, asynchronously:
  - state = IDLE, round-robin pointer favours inst.
  - All outputs = 0, conflict_cnt = 0.
REQ-038 A reset in ISSUE or WAIT_R SHALL abandon the transaction; no response is forwarded afterward.

Verification
REQ-039 Inst read at 0x100 alone, mem_req_ready=1, mem_rvalid two cycles later with 0xDEADBEEF:
  - inst_req_ready in cycle 0, mem_ren in cycle 1.
  - inst_valid with inst_rdata = 0xDEADBEEF.
  - data_rvalid = 0.
REQ-040 DATA_PRIO=1, simultaneous inst read 0x200 and data read 0x300:
  - 0x300 issued first, then 0x200.
  - conflict_cnt = 1.
REQ-041 DATA_PRIO=0, four back-to-back conflicting read pairs:
  - Grants are inst, data, inst, data, ...
  - conflict_cnt increments on each conflict.
REQ-042 Data write to 0x40, wdata 0x12345678, wstrb 0x3, mem_req_ready low for 3 cycles:
  - mem_wen held with stable payload.
  - IDLE on acceptance; no response expected.
REQ-043 inst_ready=0 for 4 cycles while mem_rvalid=1:
  - mem_rready = 0 and FSM stays in WAIT_R.
  - Completes on inst_ready=1.
REQ-044 rst asserted in WAIT_R:
  - Immediate IDLE, outputs 0.
  - A subsequent mem_rvalid produces no inst_valid or data_rvalid.
